sram_write_monitor: RTL and testbench
=====================================

# sram_write_monitor

Synthesizable, parametrised monitor that watches the project's external SRAM write port and checks, in hardware, what the simulation bench checks in software. It tracks NUM_REGIONS address regions and, for each, keeps a write count, an order check and a running checksum. It also flags writes that fall outside every region and captures the first error address. It sits beside the SRAM interface in the top level, tapping the same we_n/address/write_data nets. Results are shown on LEDs/seven-segment or read by the UART path.

## Interface
Parameters:
- ADDR_W, 18, SRAM word address width
- DATA_W, 16, SRAM data width
- NUM_REGIONS, 3, number of monitored regions (1..8)
- CNT_W, 18, per-region counter width
- REGION_BASE, {18'd57600, 18'd38400, 18'd0}, packed NUM_REGIONS*ADDR_W region bases; region 0 in the LSBs (Y, U, V)
- REGION_SIZE, {18'd19200, 18'd19200, 18'd38400}, packed NUM_REGIONS*CNT_W region sizes in words

Ports:
- Clock_50  in  1  clock
- Reset  in  1  asynchronous, active-high reset
- Clear  in  1  synchronous clear of all state
- Enable  in  1  count writes only while high
- Order_check_en  in  1  enables the ascending-address check
- SRAM_we_n  in  1  tapped write enable, active low
- SRAM_address  in  ADDR_W  tapped address
- SRAM_write_data  in  DATA_W  tapped data
- Sel  in  max(1,$clog2(NUM_REGIONS))  region select for the readout ports
- Count_o  out  CNT_W  write count of region Sel
- Checksum_o  out  DATA_W  checksum of region Sel
- Region_done_o  out  NUM_REGIONS  count == size, per region
- All_done_o  out  1  state == S_COMPLETE
- Out_of_region_o  out  1  sticky
- Order_error_o  out  NUM_REGIONS  sticky, per region
- Late_write_o  out  1  sticky; set by a write after completion
- Error_count_o  out  16  total errors, saturating
- First_error_valid_o  out  1  sticky
- First_error_address_o  out  ADDR_W  address of the first error

## Operation
- **Write event:** Enable && !SRAM_we_n, sampled at the rising edge. Back-to-back events are allowed, one per cycle.
- **Region decode:** a write hits region i when base_i <= addr < base_i + size_i. Comparisons are unsigned and use ADDR_W+1 bits so base+size cannot wrap. If regions overlap, the lowest index wins. A write that hits no region sets Out_of_region_o.
- **Count:** the hit region's counter increments and saturates at 2^CNT_W-1. Region_done_o[i] = (count_i == size_i). A write to a region whose count is already >= size also sets Order_error_o[i].
- **Order check:** only when Order_check_en=1. Expected address = base_i + count_i, taken before the increment. On a mismatch, set Order_error_o[i]. The write is still counted and checksummed.
- **Checksum:** on each hit, chk_i = {chk_i[DATA_W-2:0], chk_i[DATA_W-1]} ^ data. This is a rotate-left followed by XOR, so it is order-sensitive.
- **Error accounting:** each erroneous event adds 1 to Error_count_o, which saturates at 16'hFFFF. The first erroneous event latches First_error_address_o and sets First_error_valid_o.
- **FSM:**
  - S_IDLE → S_ARMED on the first write event.
  - S_ARMED → S_COMPLETE when all Region_done bits are 1.
  - In S_COMPLETE, any write event sets Late_write_o, counts as an error, and the FSM stays in S_COMPLETE.
  - Clear returns the FSM to S_IDLE from any state.

## Timing
- Stage 1 registers we_n, address, data and Enable.
- Stage 2 decodes, updates counters, checksums and flags, and steps the FSM.
- All outputs are registered or derived from registered state. Latency is 2 cycles from the write edge to the updated output.
- Count_o and Checksum_o are combinational muxes of registered state on Sel, so a Sel change is visible in the same cycle.
- Reset: every output and internal register is 0 and the FSM is in S_IDLE. A reset mid-stream discards any in-flight pipeline entry.
- Clear has the same effect as Reset, one cycle after the edge where Clear=1. It also flushes the stage-1 register. If Clear and a write event occur in the same cycle, the write is dropped.
- Enable low blocks new events only. An event already in stage 1 still completes.

## Structure
- Package sram_monitor_pkg holds:
  - the state typedef, monitor_state_t {S_IDLE, S_ARMED, S_COMPLETE};
  - the checksum function;
  - the default Y/U/V base and size constants.
- Sub-module sram_region_tracker covers one region: decode hit, count, order check and checksum. It is instantiated NUM_REGIONS times with a generate loop.
- The top block holds:
  - the pipeline register;
  - the priority resolution for overlapping regions;
  - the error capture;
  - the FSM.

## Test plan
- **Full Y/U/V sweep:** sequential writes to 0..76799, data = addr[15:0]. Required: Count_o = 38400/19200/19200 for regions 0/1/2, All_done_o=1, and all error flags 0.
- **Out-of-region write:** write 16'h1234 to 18'd76800. Required: Out_of_region_o=1, First_error_address_o=76800, Error_count_o=1.
- **Order check on:** writes to 0, 1, 3. Required: Order_error_o[0]=1, First_error_address_o=3, Count_o(Sel=0)=3. With Order_check_en=0 and the same writes, no error is flagged.
- **Checksum:** region 1, writes of 16'h8001 then 16'h0001 to 38400 and 38401. Required: chk = 8001 after the first write, then rotl(8001)=0003, ^0001 = 16'h0002.
- **Late write:** after All_done_o, write to address 0. Required: Late_write_o=1 and Order_error_o[0]=1.
- **Clear and reset:** Clear asserted together with a write; Reset asserted mid-sweep. Required: all outputs 0, FSM in S_IDLE, and the dropped write is not counted.

Source files
------------

// File: rtl/sram_write_monitor_pkg.sv
// Shared types and helpers for the SRAM write monitor: FSM states,
// the order-sensitive checksum step and the default Y/U/V frame layout.
package sram_monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_COMPLETE = 2'd2
  } monitor_state_t;

  // Widest data bus the checksum helper handles.
  localparam int CHK_MAX_W = 64;

  // Default frame layout in SRAM words: Y plane, then U, then V.
  localparam logic [17:0] Y_BASE = 18'd0;
  localparam logic [17:0] U_BASE = 18'd38400;
  localparam logic [17:0] V_BASE = 18'd57600;
  localparam logic [17:0] Y_SIZE = 18'd38400;
  localparam logic [17:0] U_SIZE = 18'd19200;
  localparam logic [17:0] V_SIZE = 18'd19200;

  localparam logic [53:0] DEF_REGION_BASE = {V_BASE, U_BASE, Y_BASE};
  localparam logic [53:0] DEF_REGION_SIZE = {V_SIZE, U_SIZE, Y_SIZE};

  // Rotate-left by one within 'width' bits, then XOR in the new data.
  // Inputs must have their bits above 'width' cleared.
  function automatic logic [CHK_MAX_W-1:0] chk_step(
    input logic [CHK_MAX_W-1:0] chk,
    input logic [CHK_MAX_W-1:0] data,
    input int unsigned          width
  );
    logic [CHK_MAX_W-1:0] mask;
    logic [CHK_MAX_W-1:0] rot;
    mask = (width >= CHK_MAX_W) ? '1
                                : ((CHK_MAX_W'(1) << width) - CHK_MAX_W'(1));
    rot  = ((chk << 1) | (chk >> (width - 1))) & mask;
    return (rot ^ data) & mask;
  endfunction

endpackage

// File: rtl/sram_write_monitor_if.sv
// Tap of the external SRAM write port. The SRAM controller drives it
// (master); the monitor only listens (slave).
interface sram_write_monitor_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              SRAM_we_n;
  logic [ADDR_W-1:0] SRAM_address;
  logic [DATA_W-1:0] SRAM_write_data;

  modport master (output SRAM_we_n, output SRAM_address, output SRAM_write_data);
  modport slave  (input  SRAM_we_n, input  SRAM_address, input  SRAM_write_data);
endinterface

// File: rtl/sram_region_tracker.sv
// One monitored address region: decodes hits, counts accepted writes,
// checks that writes arrive in ascending order and folds the data into a
// running checksum. The parent decides which region owns a write (upd).
module sram_region_tracker
  import sram_monitor_pkg::*;
#(
  parameter int                ADDR_W = 18,
  parameter int                DATA_W = 16,
  parameter int                CNT_W  = 18,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter logic [CNT_W-1:0]  SIZE   = '0
) (
  input  logic              Clock_50,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              Order_check_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              upd,
  output logic              hit,
  output logic              err_evt,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] checksum,
  output logic              done,
  output logic              order_error
);

  // One spare bit so base+size and base+count never wrap.
  localparam int CW = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;

  logic [CW-1:0]     a_x, lo_x, hi_x, exp_x;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] chk_q, chk_next;
  logic              ord_q;

  assign a_x   = CW'(addr);
  assign lo_x  = CW'(BASE);
  assign hi_x  = CW'(BASE) + CW'(SIZE);
  assign exp_x = CW'(BASE) + CW'(cnt_q);

  assign hit = (a_x >= lo_x) && (a_x < hi_x);

  // A write is bad if the region is already full, or, with ordering
  // enabled, if it is not the next address in sequence.
  assign err_evt = (cnt_q >= SIZE) || (Order_check_en && (a_x != exp_x));

  assign chk_next = DATA_W'(chk_step(CHK_MAX_W'(chk_q), CHK_MAX_W'(data), DATA_W));

  assign count       = cnt_q;
  assign checksum    = chk_q;
  assign done        = (cnt_q == SIZE);
  assign order_error = ord_q;

  // Count, checksum and sticky order flag for writes owned by this region.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
      chk_q <= '0;
      ord_q <= 1'b0;
    end else if (Clear) begin
      cnt_q <= '0;
      chk_q <= '0;
      ord_q <= 1'b0;
    end else if (upd) begin
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      chk_q <= chk_next;
      if (err_evt) ord_q <= 1'b1;
    end
  end

endmodule

// File: rtl/sram_write_monitor.sv
// Hardware scoreboard for the SRAM write port: per-region counts, order
// checks and checksums, out-of-region and late-write detection, error
// accounting with first-error capture, and a completion FSM.
// Two stages: stage 1 samples the tapped bus, stage 2 updates state.
module sram_write_monitor
  import sram_monitor_pkg::*;
#(
  parameter int                            ADDR_W      = 18,
  parameter int                            DATA_W      = 16,
  parameter int                            NUM_REGIONS = 3,
  parameter int                            CNT_W       = 18,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS*CNT_W-1:0]  REGION_SIZE = DEF_REGION_SIZE,
  localparam int SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                   Clock_50,
  input  logic                   Reset,
  input  logic                   Clear,
  input  logic                   Enable,
  input  logic                   Order_check_en,
  sram_write_monitor_if.slave    sram,
  input  logic [SEL_W-1:0]       Sel,
  output logic [CNT_W-1:0]       Count_o,
  output logic [DATA_W-1:0]      Checksum_o,
  output logic [NUM_REGIONS-1:0] Region_done_o,
  output logic                   All_done_o,
  output logic                   Out_of_region_o,
  output logic [NUM_REGIONS-1:0] Order_error_o,
  output logic                   Late_write_o,
  output logic [15:0]            Error_count_o,
  output logic                   First_error_valid_o,
  output logic [ADDR_W-1:0]      First_error_address_o
);

  // Stage 1: the write event (we_n and Enable folded together) plus its
  // address and data.
  logic              s1_vld;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data;

  logic [NUM_REGIONS-1:0]             hit, win, upd, trk_err, done, ord_err;
  logic [NUM_REGIONS-1:0][CNT_W-1:0]  cnt_arr;
  logic [NUM_REGIONS-1:0][DATA_W-1:0] chk_arr;

  logic any_hit, found, late, region_err, evt_err;
  monitor_state_t state_q, state_d;

  logic              oor_q, late_q, fev_q;
  logic [15:0]       ecnt_q;
  logic [ADDR_W-1:0] fea_q;

  // Stage-1 capture; Clear flushes it so a write coinciding with Clear is lost.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      s1_vld  <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
    end else if (Clear) begin
      s1_vld  <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
    end else begin
      s1_vld  <= Enable && !sram.SRAM_we_n;
      s1_addr <= sram.SRAM_address;
      s1_data <= sram.SRAM_write_data;
    end
  end

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    sram_region_tracker #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W),
      .BASE   (REGION_BASE[g*ADDR_W +: ADDR_W]),
      .SIZE   (REGION_SIZE[g*CNT_W +: CNT_W])
    ) u_trk (
      .Clock_50       (Clock_50),
      .Reset          (Reset),
      .Clear          (Clear),
      .Order_check_en (Order_check_en),
      .addr           (s1_addr),
      .data           (s1_data),
      .upd            (upd[g]),
      .hit            (hit[g]),
      .err_evt        (trk_err[g]),
      .count          (cnt_arr[g]),
      .checksum       (chk_arr[g]),
      .done           (done[g]),
      .order_error    (ord_err[g])
    );
  end

  // Overlapping regions: the lowest-indexed hit owns the write.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      win[i] = hit[i] && !found;
      found  = found || hit[i];
    end
  end

  assign any_hit    = |hit;
  assign upd        = win & {NUM_REGIONS{s1_vld}};
  assign late       = (state_q == S_COMPLETE);
  assign region_err = |(win & trk_err);
  // Several faults on one write still count as a single error.
  assign evt_err    = s1_vld && (!any_hit || late || region_err);

  // Sticky flags, saturating error count and first-error capture.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      oor_q  <= 1'b0;
      late_q <= 1'b0;
      fev_q  <= 1'b0;
      ecnt_q <= '0;
      fea_q  <= '0;
    end else if (Clear) begin
      oor_q  <= 1'b0;
      late_q <= 1'b0;
      fev_q  <= 1'b0;
      ecnt_q <= '0;
      fea_q  <= '0;
    end else if (s1_vld) begin
      if (!any_hit) oor_q  <= 1'b1;
      if (late)     late_q <= 1'b1;
      if (evt_err) begin
        if (ecnt_q != 16'hFFFF) ecnt_q <= ecnt_q + 16'd1;
        if (!fev_q) begin
          fev_q <= 1'b1;
          fea_q <= s1_addr;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset)      state_q <= S_IDLE;
    else if (Clear) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // FSM next state: arm on first write, complete once every region is full.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (s1_vld) state_d = S_ARMED;
      S_ARMED:    if (&done)  state_d = S_COMPLETE;
      S_COMPLETE: state_d = S_COMPLETE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Readout mux; an unused Sel code reads as zero.
  always_comb begin
    Count_o    = '0;
    Checksum_o = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (Sel == SEL_W'(i)) begin
        Count_o    = cnt_arr[i];
        Checksum_o = chk_arr[i];
      end
    end
  end

  assign Region_done_o         = done;
  assign All_done_o            = (state_q == S_COMPLETE);
  assign Out_of_region_o       = oor_q;
  assign Order_error_o         = ord_err;
  assign Late_write_o          = late_q;
  assign Error_count_o         = ecnt_q;
  assign First_error_valid_o   = fev_q;
  assign First_error_address_o = fea_q;

endmodule

// File: tb/tb_sram_write_monitor.sv
// Bench for sram_write_monitor. Runs the Y/U/V layout scaled down 50x
// (sizes 768/384/384) so a full-frame sweep stays short. A behavioural
// model tracks per-region counts, checksums and flags event by event and
// is compared against the DUT on every negative edge; directed scenarios
// add literal expectations on top.
module tb_sram_write_monitor;

  localparam int AW = 18, DW = 16, NR = 3, CW = 18;
  localparam logic [NR*AW-1:0] RB = {18'd1152, 18'd768, 18'd0};
  localparam logic [NR*CW-1:0] RS = {18'd384, 18'd384, 18'd768};
  localparam int MB [NR] = '{0, 768, 1152};
  localparam int MS [NR] = '{768, 384, 384};
  localparam int FRAME = 1536;

  logic          Clock_50 = 1'b0;
  logic          Reset = 1'b1, Clear = 1'b0, Enable = 1'b0, Order_check_en = 1'b1;
  logic [1:0]    Sel = 2'd0;
  logic [CW-1:0] Count_o;
  logic [DW-1:0] Checksum_o;
  logic [NR-1:0] Region_done_o, Order_error_o;
  logic          All_done_o, Out_of_region_o, Late_write_o, First_error_valid_o;
  logic [15:0]   Error_count_o;
  logic [AW-1:0] First_error_address_o;

  int vectors = 0, miscompares = 0;

  sram_write_monitor_if #(.ADDR_W(AW), .DATA_W(DW)) sram ();

  sram_write_monitor #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REGIONS(NR), .CNT_W(CW),
    .REGION_BASE(RB), .REGION_SIZE(RS)
  ) u_dut (
    .Clock_50(Clock_50), .Reset(Reset), .Clear(Clear), .Enable(Enable),
    .Order_check_en(Order_check_en), .sram(sram), .Sel(Sel),
    .Count_o(Count_o), .Checksum_o(Checksum_o), .Region_done_o(Region_done_o),
    .All_done_o(All_done_o), .Out_of_region_o(Out_of_region_o),
    .Order_error_o(Order_error_o), .Late_write_o(Late_write_o),
    .Error_count_o(Error_count_o), .First_error_valid_o(First_error_valid_o),
    .First_error_address_o(First_error_address_o)
  );

  always #10 Clock_50 = ~Clock_50;

  // ---------------- behavioural model ----------------
  int unsigned m_cnt [NR];
  bit [15:0]   m_chk [NR];
  bit [NR-1:0] m_ord;
  bit          m_oor, m_late, m_fev;
  int unsigned m_ecnt, m_fea;
  int          m_state;             // 0 idle, 1 armed, 2 complete
  bit          p_vld;
  int unsigned p_addr;
  bit [15:0]   p_data;

  function automatic void m_clear();
    for (int i = 0; i < NR; i++) begin m_cnt[i] = 0; m_chk[i] = 0; end
    m_ord = '0; m_oor = 0; m_late = 0; m_fev = 0;
    m_ecnt = 0; m_fea = 0; m_state = 0; p_vld = 0;
  endfunction

  function automatic void m_event(int unsigned a, bit [15:0] d, int st, bit oen);
    bit err;
    int r;
    err = (st == 2);
    if (err) m_late = 1;
    r = -1;
    for (int i = 0; i < NR; i++)
      if (r < 0 && a >= MB[i] && a < MB[i] + MS[i]) r = i;
    if (r < 0) begin
      m_oor = 1; err = 1;
    end else begin
      if (m_cnt[r] >= MS[r] || (oen && a != MB[r] + m_cnt[r])) begin
        m_ord[r] = 1; err = 1;
      end
      if (m_cnt[r] < 262143) m_cnt[r]++;
      m_chk[r] = 16'((((32'(m_chk[r]) << 1) | (32'(m_chk[r]) >> 15)) & 32'hFFFF) ^ 32'(d));
    end
    if (err) begin
      if (m_ecnt < 65535) m_ecnt++;
      if (!m_fev) begin m_fev = 1; m_fea = a; end
    end
  endfunction

  always @(posedge Clock_50 or posedge Reset) begin
    int  st;
    bit  full;
    if (Reset || Clear) begin
      m_clear();
    end else begin
      st   = m_state;
      full = 1;
      for (int i = 0; i < NR; i++) if (m_cnt[i] != MS[i]) full = 0;
      if (p_vld) m_event(p_addr, p_data, st, Order_check_en);
      if (st == 0 && p_vld)     m_state = 1;
      else if (st == 1 && full) m_state = 2;
      p_vld  = Enable && !sram.SRAM_we_n;
      p_addr = 32'(sram.SRAM_address);
      p_data = sram.SRAM_write_data;
    end
  end

  // ---------------- checking ----------------
  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit [NR-1:0] done_e;
    logic [63:0] ce, ke;
    for (int i = 0; i < NR; i++) done_e[i] = (m_cnt[i] == MS[i]);
    ce = 0; ke = 0;
    if (Sel < NR) begin ce = 64'(m_cnt[Sel]); ke = 64'(m_chk[Sel]); end
    cmp("Count_o",        Count_o, ce);
    cmp("Checksum_o",     Checksum_o, ke);
    cmp("Region_done_o",  Region_done_o, done_e);
    cmp("All_done_o",     All_done_o, m_state == 2);
    cmp("Out_of_region",  Out_of_region_o, m_oor);
    cmp("Order_error_o",  Order_error_o, m_ord);
    cmp("Late_write_o",   Late_write_o, m_late);
    cmp("Error_count_o",  Error_count_o, m_ecnt);
    cmp("First_err_vld",  First_error_valid_o, m_fev);
    cmp("First_err_addr", First_error_address_o, m_fea);
  endtask

  always @(negedge Clock_50) if (!Reset) check_model();

  // ---------------- stimulus ----------------
  task automatic drive(input bit en, input bit we_n, input int unsigned a,
                       input bit [15:0] d, input bit clr);
    @(negedge Clock_50); #1;
    Enable               = en;
    sram.SRAM_we_n       = we_n;
    sram.SRAM_address    = AW'(a);
    sram.SRAM_write_data = d;
    Clear                = clr;
    Sel                  = 2'($urandom_range(0, 3));
  endtask

  task automatic wr(input int unsigned a, input bit [15:0] d);
    drive(1'b1, 1'b0, a, d, 1'b0);
  endtask

  // Non-events: either Enable low or we_n high, with junk on the bus.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0)
        drive(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 2000), 16'($urandom), 1'b0);
      else
        drive(1'b1, 1'b1, $urandom_range(0, 2000), 16'($urandom), 1'b0);
    end
  endtask

  task automatic do_clear();
    drive(1'b0, 1'b1, 0, 16'h0, 1'b1);
    idle(1);
  endtask

  task automatic peek(input int s);
    Sel = 2'(s); #1;
  endtask

  initial begin
    sram.SRAM_we_n = 1'b1; sram.SRAM_address = '0; sram.SRAM_write_data = '0;
    repeat (2) @(negedge Clock_50);
    peek(0);
    cmp("rst Count_o", Count_o, 0);
    cmp("rst Err_cnt", Error_count_o, 0);
    cmp("rst FEV",     First_error_valid_o, 0);
    cmp("rst done",    Region_done_o, 0);
    cmp("rst state",   u_dut.state_q, 0);
    @(negedge Clock_50); #1; Reset = 1'b0;

    // Full frame sweep, data = address, ordering on, random idle gaps.
    for (int a = 0; a < FRAME; a++) begin
      if ($urandom_range(0, 7) == 0) idle(1);
      wr(a, 16'(a));
    end
    idle(3);
    peek(0); cmp("sweep cnt Y", Count_o, 768);
    peek(1); cmp("sweep cnt U", Count_o, 384);
    peek(2); cmp("sweep cnt V", Count_o, 384);
    cmp("sweep all_done", All_done_o, 1);
    cmp("sweep done",     Region_done_o, 3'b111);
    cmp("sweep ord",      Order_error_o, 0);
    cmp("sweep errcnt",   Error_count_o, 0);
    cmp("sweep oor",      Out_of_region_o, 0);

    // Late write after completion.
    wr(0, 16'h5555); idle(3);
    cmp("late flag",  Late_write_o, 1);
    cmp("late ord0",  Order_error_o[0], 1);
    cmp("late ecnt",  Error_count_o, 1);
    cmp("late fea",   First_error_address_o, 0);
    cmp("late still", All_done_o, 1);

    do_clear();
    cmp("clr state", u_dut.state_q, 0);
    cmp("clr late",  Late_write_o, 0);
    cmp("clr done",  All_done_o, 0);

    // Out-of-region write.
    wr(FRAME, 16'h1234); idle(3);
    cmp("oor flag", Out_of_region_o, 1);
    cmp("oor fea",  First_error_address_o, FRAME);
    cmp("oor ecnt", Error_count_o, 1);
    do_clear();

    // Order check: 0, 1, 3.
    wr(0, 16'h1); wr(1, 16'h2); wr(3, 16'h3); idle(3);
    peek(0);
    cmp("ord err0", Order_error_o[0], 1);
    cmp("ord fea",  First_error_address_o, 3);
    cmp("ord cnt",  Count_o, 3);
    do_clear();
    Order_check_en = 1'b0;
    wr(0, 16'h1); wr(1, 16'h2); wr(3, 16'h3); idle(3);
    peek(0);
    cmp("noord err", Order_error_o, 0);
    cmp("noord cnt", Count_o, 3);
    cmp("noord ecnt", Error_count_o, 0);
    Order_check_en = 1'b1;
    do_clear();

    // Checksum on region 1.
    wr(768, 16'h8001); idle(3);
    peek(1); cmp("chk first", Checksum_o, 16'h8001);
    wr(769, 16'h0001); idle(3);
    peek(1); cmp("chk second", Checksum_o, 16'h0002);
    cmp("chk cnt", Count_o, 2);

    // Write in stage 1 at Clear, plus a write in the Clear cycle: both lost.
    wr(770, 16'hAAAA);
    drive(1'b1, 1'b0, 771, 16'hBBBB, 1'b1);
    idle(3);
    peek(1); cmp("clrwr cnt", Count_o, 0);
    cmp("clrwr chk",   Checksum_o, 0);
    cmp("clrwr ecnt",  Error_count_o, 0);
    cmp("clrwr state", u_dut.state_q, 0);

    // Reset mid-sweep with a write in flight.
    for (int a = 0; a < 100; a++) wr(a, 16'(a));
    @(negedge Clock_50); #1; Reset = 1'b1; Enable = 1'b0;
    #1;
    peek(0);
    cmp("rstmid cnt",   Count_o, 0);
    cmp("rstmid state", u_dut.state_q, 0);
    @(negedge Clock_50); #1; Reset = 1'b0;
    idle(3);
    peek(0); cmp("rstmid after", Count_o, 0);
    cmp("rstmid fev", First_error_valid_o, 0);

    // Randomised traffic, mostly in-order per region with strays and clears.
    for (int ph = 0; ph < 10; ph++) begin
      Order_check_en = 1'($urandom_range(0, 1));
      for (int c = 0; c < 300; c++) begin
        int r;
        int g;
        r = $urandom_range(0, 99);
        if (r < 2)       drive(1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 1700), 16'($urandom), 1'b1);
        else if (r < 20) idle(1);
        else if (r < 70) begin
          g = $urandom_range(0, NR - 1);
          wr(MB[g] + m_cnt[g], 16'($urandom));
        end else wr($urandom_range(0, 1700), 16'($urandom));
      end
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
